// File: rtl/mod13_pkg.sv
// mod13_pkg: shared constants, monitor states and the mod-13 step function.
package mod13_pkg;
   localparam int MOD = 13;
   localparam int CNT_W = 4;
   typedef enum logic [1:0] {INIT, TRACK, ERROR} state_t;
   // One extra bit keeps MOD-1 and the +1/-1 results from aliasing.
   function automatic logic [CNT_W:0] mod13_next(input logic [CNT_W-1:0] cnt, input logic dir);
      logic [CNT_W:0] c;
      c = {1'b0, cnt};
      return dir ? ((c == (CNT_W+1)'(MOD-1)) ? '0 : c + 1'b1)
                 : ((c == '0) ? (CNT_W+1)'(MOD-1) : c - 1'b1);
   endfunction
endpackage

// File: rtl/mod13_wrap_monitor_if.sv
// mod13_wrap_monitor_if: counter sample inputs and monitor status outputs.
interface mod13_wrap_monitor_if import mod13_pkg::*; #(parameter int LAP_W = 8);
   logic [CNT_W-1:0] count;
   logic x;
   logic clr_err;
   logic valid;
   logic wrap_up;
   logic wrap_dn;
   logic signed [LAP_W-1:0] laps;
   logic err_step;
   logic err_range;
   modport master (output count, x, clr_err, input valid, wrap_up, wrap_dn, laps, err_step, err_range);
   modport slave (input count, x, clr_err, output valid, wrap_up, wrap_dn, laps, err_step, err_range);
endinterface

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: signed up/down counter that clamps at its extremes.
module sat_updown_counter #(parameter int LAP_W = 8) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic signed [LAP_W-1:0] q
);
   localparam logic signed [LAP_W-1:0] MAX = {1'b0, {(LAP_W-1){1'b1}}};
   localparam logic signed [LAP_W-1:0] MIN = {1'b1, {(LAP_W-1){1'b0}}};
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (inc && !dec && q != MAX) q <= q + 1'b1;
      else if (dec && !inc && q != MIN) q <= q - 1'b1;
endmodule

// File: rtl/mod13_wrap_monitor.sv
// mod13_wrap_monitor: checks mod-13 counter steps, pulses on wraps, keeps a lap total.
module mod13_wrap_monitor import mod13_pkg::*; #(parameter int LAP_W = 8) (
   input logic clk,
   input logic rst,
   mod13_wrap_monitor_if.slave bus
);
   state_t state, state_n;
   logic [CNT_W-1:0] prev_cnt;
   logic prev_x;
   logic [CNT_W:0] exp_cnt;
   logic in_range, step_ok;
   logic err_step, err_range, wrap_up, wrap_dn;
   logic step_n, range_n, up_n, dn_n;
   logic signed [LAP_W-1:0] laps;
   // The sampled step was produced by the counter with the previous direction.
   assign exp_cnt = mod13_next(prev_cnt, prev_x);
   assign in_range = bus.count < CNT_W'(MOD);
   assign step_ok = {1'b0, bus.count} == exp_cnt;
   always_comb begin
      state_n = state;
      step_n = err_step;
      range_n = err_range;
      up_n = 1'b0;
      dn_n = 1'b0;
      if (bus.clr_err) begin
         state_n = INIT;
         step_n = 1'b0;
         range_n = 1'b0;
      end else if (state == INIT || state == TRACK) begin
         if (!in_range) begin
            state_n = ERROR;
            range_n = 1'b1;
         end else if (state == INIT) state_n = TRACK;
         else if (!step_ok) begin
            state_n = ERROR;
            step_n = 1'b1;
         end else begin
            up_n = prev_x && prev_cnt == CNT_W'(MOD-1);
            dn_n = !prev_x && prev_cnt == '0;
         end
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= INIT;
         prev_cnt <= '0;
         prev_x <= 1'b0;
         err_step <= 1'b0;
         err_range <= 1'b0;
         wrap_up <= 1'b0;
         wrap_dn <= 1'b0;
      end else begin
         state <= state_n;
         prev_cnt <= bus.count;
         prev_x <= bus.x;
         err_step <= step_n;
         err_range <= range_n;
         wrap_up <= up_n;
         wrap_dn <= dn_n;
      end
   sat_updown_counter #(.LAP_W(LAP_W)) u_laps (
      .clk(clk),
      .rst(rst),
      .inc(up_n),
      .dec(dn_n),
      .q(laps)
   );
   assign bus.valid = state == TRACK;
   assign bus.wrap_up = wrap_up;
   assign bus.wrap_dn = wrap_dn;
   assign bus.laps = laps;
   assign bus.err_step = err_step;
   assign bus.err_range = err_range;
endmodule

// File: tb/tb_mod13_wrap_monitor.sv
// tb_mod13_wrap_monitor: directed vectors plus a behavioural mod-13 counter driving two lap widths.
module tb_mod13_wrap_monitor;
   import mod13_pkg::*;
   typedef struct {
      logic [CNT_W-1:0] c;
      logic xx;
      logic cl;
      int v, up, dn, lp, st, rg;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [CNT_W-1:0] count = '0;
   logic x = 1'b0;
   logic clr = 1'b0;
   int checks = 0;
   int errors = 0;
   int l8 = 0;
   int l4 = 0;
   logic [CNT_W-1:0] pc = '0;
   logic px = 1'b0;
   bit trk = 1'b0;
   bit last_up = 1'b0;
   vec_t tbl [19];
   mod13_wrap_monitor_if #(.LAP_W(8)) b8 ();
   mod13_wrap_monitor_if #(.LAP_W(4)) b4 ();
   assign b8.count = count;
   assign b8.x = x;
   assign b8.clr_err = clr;
   assign b4.count = count;
   assign b4.x = x;
   assign b4.clr_err = clr;
   mod13_wrap_monitor #(.LAP_W(8)) d8 (.clk(clk), .rst(rst), .bus(b8));
   mod13_wrap_monitor #(.LAP_W(4)) d4 (.clk(clk), .rst(rst), .bus(b4));
   always #5 clk = ~clk;
   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask
   task automatic chk_all(input string t, input int v, up, dn, lp8, lp4, st, rg);
      chk({t, " valid"}, int'(b8.valid), v);
      chk({t, " wrap_up"}, int'(b8.wrap_up), up);
      chk({t, " wrap_dn"}, int'(b8.wrap_dn), dn);
      chk({t, " laps8"}, int'(b8.laps), lp8);
      chk({t, " laps4"}, int'(b4.laps), lp4);
      chk({t, " err_step"}, int'(b8.err_step), st);
      chk({t, " err_range"}, int'(b8.err_range), rg);
   endtask
   function automatic int sat(input int v, input int w);
      int lo, hi;
      lo = -(1 << (w - 1));
      hi = (1 << (w - 1)) - 1;
      return v > hi ? hi : (v < lo ? lo : v);
   endfunction
   // Behaves like the upstream counter: the value seen at an edge steps using the x seen at that edge.
   task automatic run_ctr(input int n, input logic dir);
      for (int i = 0; i < n; i++) begin
         bit eu, ed;
         x = dir;
         eu = trk && px && pc == 4'd12 && count == 4'd0;
         ed = trk && !px && pc == 4'd0 && count == 4'd12;
         @(posedge clk);
         #1;
         if (eu) begin l8 = sat(l8 + 1, 8); l4 = sat(l4 + 1, 4); end
         if (ed) begin l8 = sat(l8 - 1, 8); l4 = sat(l4 - 1, 4); end
         chk_all($sformatf("ctr%0d", i), 1, int'(eu), int'(ed), l8, l4, 0, 0);
         last_up = eu;
         pc = count;
         px = x;
         count = CNT_W'(mod13_next(count, x));
         trk = 1'b1;
      end
   endtask
   initial begin
      tbl[0]  = '{4'd3,  1'b1, 1'b1, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{4'd3,  1'b1, 1'b0, 1, 0, 0, 0, 0, 0};
      tbl[2]  = '{4'd4,  1'b1, 1'b0, 1, 0, 0, 0, 0, 0};
      tbl[3]  = '{4'd6,  1'b1, 1'b0, 0, 0, 0, 0, 1, 0};
      tbl[4]  = '{4'd7,  1'b1, 1'b0, 0, 0, 0, 0, 1, 0};
      tbl[5]  = '{4'd7,  1'b1, 1'b1, 0, 0, 0, 0, 0, 0};
      tbl[6]  = '{4'd8,  1'b1, 1'b0, 1, 0, 0, 0, 0, 0};
      tbl[7]  = '{4'd14, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1};
      tbl[8]  = '{4'd0,  1'b1, 1'b1, 0, 0, 0, 0, 0, 0};
      tbl[9]  = '{4'd15, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1};
      tbl[10] = '{4'd12, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0};
      tbl[11] = '{4'd12, 1'b1, 1'b0, 1, 0, 0, 0, 0, 0};
      tbl[12] = '{4'd0,  1'b1, 1'b0, 1, 1, 0, 1, 0, 0};
      tbl[13] = '{4'd1,  1'b1, 1'b0, 1, 0, 0, 1, 0, 0};
      tbl[14] = '{4'd3,  1'b1, 1'b0, 0, 0, 0, 1, 1, 0};
      tbl[15] = '{4'd4,  1'b0, 1'b1, 0, 0, 0, 1, 0, 0};
      tbl[16] = '{4'd4,  1'b0, 1'b0, 1, 0, 0, 1, 0, 0};
      tbl[17] = '{4'd3,  1'b1, 1'b0, 1, 0, 0, 1, 0, 0};
      tbl[18] = '{4'd4,  1'b1, 1'b0, 1, 0, 0, 1, 0, 0};
      #12;
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
      #8 rst = 1'b0;
      #1 chk("init_valid", int'(b8.valid), 0);
      run_ctr(21, 1'b0);
      chk("laps_after_dn", int'(b8.laps), -2);
      run_ctr(30, 1'b1);
      chk("laps_after_up", int'(b8.laps), 0);
      for (int i = 0; i < 19; i++) begin
         count = tbl[i].c;
         x = tbl[i].xx;
         clr = tbl[i].cl;
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].up, tbl[i].dn, tbl[i].lp, tbl[i].lp, tbl[i].st, tbl[i].rg);
      end
      clr = 1'b0;
      l8 = 1;
      l4 = 1;
      pc = 4'd4;
      px = 1'b1;
      trk = 1'b1;
      count = 4'd5;
      run_ctr(117, 1'b1);
      chk("sat_hi laps4", int'(b4.laps), 7);
      chk("up9 laps8", int'(b8.laps), 10);
      run_ctr(260, 1'b0);
      chk("sat_lo laps4", int'(b4.laps), -8);
      chk("dn20 laps8", int'(b8.laps), -10);
      last_up = 1'b0;
      for (int k = 0; k < 20 && !last_up; k++) run_ctr(1, 1'b1);
      chk("wrap_up_before_rst", int'(b8.wrap_up), 1);
      #2 rst = 1'b1;
      #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("post_rst_valid", int'(b8.valid), 0);
      pc = '0;
      px = 1'b0;
      trk = 1'b0;
      l8 = 0;
      l4 = 0;
      count = 4'd3;
      run_ctr(2, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
